// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: dcache refill/writeback port to AXI4 master bursts.
// Line reads become LINE_BEATS-beat INCR reads; writebacks become INCR writes.
// Ports: clk, reset (async, high); rd_req/rd_type/rd_addr/rd_rdy,
//   ret_valid/ret_data; wr_req/wr_addr/wr_wstrb/wr_data/wr_rdy;
//   AXI4 AR/R (arid..rready) and AW/W/B (awid..bready) channels.
// Option: DCACHE_AXI_RAW_ORDER_EN holds reads to a line being written back.
module dcache_axi_bridge #(
   parameter int LINE_BEATS = 8,
   parameter int ID_W       = 4,
   parameter int RD_ID      = 0,
   parameter int WR_ID      = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rd_req,
   input  logic [2:0]               rd_type,
   input  logic [31:0]              rd_addr,
   output logic                     rd_rdy,
   output logic                     ret_valid,
   output logic [LINE_BEATS*32-1:0] ret_data,
   input  logic                     wr_req,
   input  logic [31:0]              wr_addr,
   input  logic [3:0]               wr_wstrb,
   input  logic [LINE_BEATS*32-1:0] wr_data,
   output logic                     wr_rdy,
   output logic [ID_W-1:0]          arid,
   output logic [31:0]              araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [ID_W-1:0]          rid,
   input  logic [31:0]              rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready,
   output logic [ID_W-1:0]          awid,
   output logic [31:0]              awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [31:0]              wdata,
   output logic [3:0]               wstrb,
   output logic                     wlast,
   output logic                     wvalid,
   input  logic                     wready,
   input  logic [ID_W-1:0]          bid,
   input  logic [1:0]               bresp,
   input  logic                     bvalid,
   output logic                     bready
);

   localparam int LW = LINE_BEATS * 32;
   localparam int CW = $clog2(LINE_BEATS);
   localparam int OB = $clog2(LINE_BEATS * 4);
   localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

   rstate_t         rstate_q, rstate_d;
   wstate_t         wstate_q, wstate_d;
   logic [31:0]     araddr_q;
   logic [7:0]      arlen_q;
   logic [2:0]      arsize_q;
   logic [CW-1:0]   rcnt_q;
   logic [LW-1:0]   ret_data_q;
   logic [31:0]     waddr_q;
   logic [3:0]      wstrb_q;
   logic [LW-1:0]   wline_q;
   logic [CW-1:0]   wcnt_q;
   logic            rd_acc;
   logic            wr_acc;
   logic            unused_ok;

   assign unused_ok = ^{rid, rresp, bid, bresp, wr_addr[OB-1:0]};

   assign rd_acc = rd_req & rd_rdy;
   assign wr_acc = wr_req & wr_rdy;

`ifdef DCACHE_AXI_RAW_ORDER_EN
   // Hold a read whose line is (or is about to be) in flight as a writeback.
   logic raw_hit;
   assign raw_hit =
      ((wstate_q != W_IDLE) && (rd_addr[31:OB] == waddr_q[31:OB])) ||
      (wr_acc && (wr_addr[31:OB] == rd_addr[31:OB]));
   assign rd_rdy = (rstate_q == R_IDLE) & ~raw_hit;
`else
   assign rd_rdy = (rstate_q == R_IDLE);
`endif

   // ---------------- read FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rstate_q <= R_IDLE;
      else       rstate_q <= rstate_d;
   end

   always_comb begin
      rstate_d = rstate_q;
      unique case (rstate_q)
         R_IDLE: if (rd_acc) rstate_d = R_AR;
         R_AR:   if (arready) rstate_d = R_DATA;
         R_DATA: if (rvalid && rlast) rstate_d = R_RET;
         R_RET:  rstate_d = R_IDLE;
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      arvalid   = (rstate_q == R_AR);
      rready    = (rstate_q == R_DATA);
      ret_valid = (rstate_q == R_RET);
   end

   assign arid     = ID_W'(RD_ID);
   assign araddr   = araddr_q;
   assign arlen    = arlen_q;
   assign arsize   = arsize_q;
   assign arburst  = 2'b01;
   assign ret_data = ret_data_q;

   // Sub-line reads clear the buffer so the single beat reads back zero-extended;
   // line reads keep old slots, so a short burst leaves stale data behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         rcnt_q     <= '0;
         ret_data_q <= '0;
      end else if (rd_acc) begin
         rcnt_q <= '0;
         if (rd_type == 3'b100) begin
            araddr_q <= {rd_addr[31:OB], {OB{1'b0}}};
            arlen_q  <= 8'(LINE_BEATS - 1);
            arsize_q <= 3'd2;
         end else begin
            araddr_q   <= rd_addr;
            arlen_q    <= '0;
            arsize_q   <= {1'b0, rd_type[1:0]};
            ret_data_q <= '0;
         end
      end else if (rstate_q == R_DATA && rvalid) begin
         ret_data_q[32*int'(rcnt_q) +: 32] <= rdata;
         rcnt_q <= rlast ? '0 : rcnt_q + CW'(1);
      end
   end

   // ---------------- write FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) wstate_q <= W_IDLE;
      else       wstate_q <= wstate_d;
   end

   always_comb begin
      wstate_d = wstate_q;
      unique case (wstate_q)
         W_IDLE: if (wr_acc) wstate_d = W_AW;
         W_AW:   if (awready) wstate_d = W_DATA;
         W_DATA: if (wready && wcnt_q == LAST) wstate_d = W_RESP;
         W_RESP: if (bvalid) wstate_d = W_IDLE;
         default: wstate_d = W_IDLE;
      endcase
   end

   always_comb begin
      wr_rdy  = (wstate_q == W_IDLE);
      awvalid = (wstate_q == W_AW);
      wvalid  = (wstate_q == W_DATA);
      wlast   = (wstate_q == W_DATA) && (wcnt_q == LAST);
      bready  = (wstate_q == W_RESP);
   end

   assign awid    = ID_W'(WR_ID);
   assign awaddr  = waddr_q;
   assign awlen   = 8'(LINE_BEATS - 1);
   assign awsize  = 3'd2;
   assign awburst = 2'b01;
   assign wdata   = wline_q[32*int'(wcnt_q) +: 32];
   assign wstrb   = wstrb_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         waddr_q <= '0;
         wstrb_q <= '0;
         wline_q <= '0;
         wcnt_q  <= '0;
      end else if (wr_acc) begin
         waddr_q <= {wr_addr[31:OB], {OB{1'b0}}};
         wstrb_q <= wr_wstrb;
         wline_q <= wr_data;
         wcnt_q  <= '0;
      end else if (wstate_q == W_DATA && wready) begin
         wcnt_q <= (wcnt_q == LAST) ? '0 : wcnt_q + CW'(1);
      end
   end

endmodule
